run_detect_scheduler: RTL

//  Shares one serial run-length detector (Mealy; z=1 on 4th+ consecutive identical bit) among NREQ requesters.

---
 rtl/run_detect_scheduler_if.sv | 38 +++
 rtl/run_detect_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/run_detect_scheduler_if.sv
// Requester, detector and result signals for run_detect_scheduler.
// hit_pos exists only when RDS_EARLY_EXIT_EN is defined.
interface run_detect_scheduler_if #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned FRAME_W = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NREQ-1:0]         req;
  logic [NREQ*FRAME_W-1:0] frame;
  logic [NREQ-1:0]         gnt;
  logic                    busy;
  logic                    det_rst;
  logic                    det_w;
  logic                    det_z;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic [CNT_W-1:0]        hit_cnt;
`ifdef RDS_EARLY_EXIT_EN
  logic [7:0]              hit_pos;
`endif

  modport master (
    output req, frame, det_z,
`ifdef RDS_EARLY_EXIT_EN
    input  hit_pos,
`endif
    input  gnt, busy, det_rst, det_w, done, done_id, hit_cnt
  );

  modport slave (
    input  req, frame, det_z,
`ifdef RDS_EARLY_EXIT_EN
    output hit_pos,
`endif
    output gnt, busy, det_rst, det_w, done, done_id, hit_cnt
  );
endinterface

// File: rtl/run_detect_scheduler.sv
// Round-robin scheduler sharing one serial run-length detector among NREQ requesters.
// Optional RDS_EARLY_EXIT_EN: stop at the first detector hit and report its bit position.
module run_detect_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned FRAME_W = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clke,
  input  logic                  rst,
  run_detect_scheduler_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DONE, ABORT} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gidx;
  logic [ID_W-1:0]    gidx_inc;
  logic [FRAME_W-1:0] shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   cnt;
  logic               pick_vld;
  logic [ID_W-1:0]    pick_idx;
  logic [FRAME_W-1:0] pick_frame;
  logic               gnt_live;
  logic               last_bit;
`ifdef RDS_EARLY_EXIT_EN
  logic [7:0]         hpos;
`endif

  // First requester at or above rr_ptr, wrapping NREQ-1 -> 0
  always_comb begin
    logic [NREQ-1:0]         req_sh;
    logic [NREQ*FRAME_W-1:0] frame_sh;
    int unsigned             j;
    pick_vld = 1'b0;
    pick_idx = '0;
    req_sh   = '0;
    j        = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j      = (32'(rr_ptr) + i) % NREQ;
      req_sh = bus.req >> j;
      if (!pick_vld && req_sh[0]) begin
        pick_vld = 1'b1;
        pick_idx = ID_W'(j);
      end
    end
    frame_sh   = bus.frame >> (32'(pick_idx) * FRAME_W);
    pick_frame = frame_sh[FRAME_W-1:0];
  end

  assign gnt_live = |(bus.req & bus.gnt);
  assign gidx_inc = (32'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
  assign last_bit = (32'(bit_idx) == FRAME_W - 1);

  always_ff @(posedge clke) begin
    if (rst) begin
      state       <= IDLE;
      bus.gnt     <= '0;
      bus.busy    <= 1'b0;
      bus.det_rst <= 1'b1;
      bus.det_w   <= 1'b0;
      bus.done    <= 1'b0;
      bus.done_id <= '0;
      bus.hit_cnt <= '0;
      rr_ptr      <= '0;
      gidx        <= '0;
      shreg       <= '0;
      bit_idx     <= '0;
      cnt         <= '0;
`ifdef RDS_EARLY_EXIT_EN
      hpos        <= '0;
      bus.hit_pos <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.det_rst <= 1'b0;
          bus.det_w   <= 1'b0;
          if (pick_vld) begin
            state       <= CLR;
            bus.busy    <= 1'b1;
            bus.gnt     <= NREQ'(1) << pick_idx;
            gidx        <= pick_idx;
            shreg       <= pick_frame;
            bit_idx     <= '0;
            cnt         <= '0;
            bus.det_rst <= 1'b1;
          end
        end
        CLR, SHIFT: begin
          if (!gnt_live) begin
            // Granted requester withdrew: clear the detector and move on
            state       <= ABORT;
            bus.det_rst <= 1'b1;
            bus.det_w   <= 1'b0;
            bus.gnt     <= '0;
            rr_ptr      <= gidx_inc;
          end else if (state == CLR) begin
            state       <= SHIFT;
            bus.det_rst <= 1'b0;
            bus.det_w   <= shreg[FRAME_W-1];
          end else begin
            shreg     <= shreg << 1;
            bit_idx   <= bit_idx + 1'b1;
            bus.det_w <= shreg[FRAME_W-2];
`ifdef RDS_EARLY_EXIT_EN
            if (bus.det_z) begin
              state     <= DONE;
              bus.det_w <= 1'b0;
              cnt       <= CNT_W'(1);
              hpos      <= 8'(bit_idx);
            end else if (last_bit) begin
              state     <= DONE;
              bus.det_w <= 1'b0;
              hpos      <= 8'(FRAME_W);
            end
`else
            if (bus.det_z && cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (last_bit) begin
              state     <= DONE;
              bus.det_w <= 1'b0;
            end
`endif
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          bus.hit_cnt <= cnt;
          bus.done_id <= gidx;
          bus.gnt     <= '0;
          rr_ptr      <= gidx_inc;
`ifdef RDS_EARLY_EXIT_EN
          bus.hit_pos <= hpos;
`endif
        end
        ABORT: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.det_rst <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
